// File: rtl/qnet_pkg.sv
// Shared QNET definitions: header field map, broadcast ID, command opcodes and decoder FSM states.
package qnet_pkg;

    localparam int HDR_CFG_LSB  = 61;
    localparam int HDR_CFG_W    = 3;
    localparam int HDR_CMD_LSB  = 56;
    localparam int HDR_CMD_W    = 5;
    localparam int HDR_FLG_LSB  = 50;
    localparam int HDR_FLG_W    = 6;
    localparam int HDR_DEST_LSB = 40;
    localparam int HDR_SRC_LSB  = 30;
    localparam int HDR_STEP_LSB = 20;
    localparam int HDR_ID0_LSB  = 10;
    localparam int HDR_ID1_LSB  = 0;
    localparam int HDR_NODE_W   = 10;

    localparam logic [9:0] BCAST_ID = 10'h3FF;

    localparam logic [4:0] _get_net  = 5'h01;
    localparam logic [4:0] _get_id   = 5'h02;
    localparam logic [4:0] _get_step = 5'h03;
    localparam logic [4:0] _get_cond = 5'h04;

    typedef struct packed {
        logic [2:0] cfg;
        logic [4:0] cmd;
        logic [5:0] flg;
        logic [9:0] dest;
        logic [9:0] src;
        logic [9:0] step;
        logic [9:0] id0;
        logic [9:0] id1;
    } qnet_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_DROP,
        ST_DEC,
        ST_DISP
    } dec_state_t;

    // STEP is compared one bit wider so that 10'h3FF + 1 cannot wrap to zero.
    function automatic logic [10:0] step_inc(input logic [9:0] step);
        return {1'b0, step} + 11'd1;
    endfunction

endpackage

// File: rtl/qnet_frame_rx.sv
// Word counter and framing checks for 4-word QNET frames; holds the captured words as one 128-bit frame.
module qnet_frame_rx (
    input  logic         clk,
    input  logic         srst,
    input  logic         rx_en,
    input  logic [31:0]  rx_tdata,
    input  logic         rx_tvalid,
    input  logic         rx_tlast,
    output logic [127:0] frame,
    output logic         frame_vld,
    output logic         frame_err
);

    logic [1:0] cnt_reg;
    logic       accept;
    logic       last_word;

    assign accept    = rx_en & rx_tvalid;
    assign last_word = (cnt_reg == 2'd3);

    // Strobes are combinational so the FSM can leave RX on the tlast handshake itself.
    assign frame_vld = accept & rx_tlast & last_word;
    assign frame_err = accept & (rx_tlast ^ last_word);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= 2'd0;
        end else if (accept) begin
            cnt_reg <= (rx_tlast || last_word) ? 2'd0 : cnt_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    word_reg <= 32'd0;
                end else if (accept && cnt_reg == 2'(gi)) begin
                    word_reg <= rx_tdata;
                end
            end
        end
    endgenerate

    // Header is {word0, word1}; payload is {D1, D0} = {word3, word2}.
    assign frame = {gen_word[0].word_reg, gen_word[1].word_reg,
                    gen_word[3].word_reg, gen_word[2].word_reg};

endmodule

// File: rtl/qnet_cmd_dec.sv
// QNET receive-side command decoder: deframes RX words, delivers local commands, forwards ring traffic.
// Optional QNET_DEC_STATS_EN adds saturating 16-bit frame statistics outputs.
module qnet_cmd_dec #(
    parameter logic [9:0] BCAST_ID = qnet_pkg::BCAST_ID,
    parameter int         ACK_TO   = 1023
) (
    input  logic        t_clk_i,
    input  logic        t_rst_i,
    input  logic [9:0]  param_ID,
    input  logic [9:0]  param_NN,
    input  logic [31:0] rx_tdata_i,
    input  logic        rx_tvalid_i,
    input  logic        rx_tlast_i,
    output logic        rx_tready_o,
    output logic        net_cmd_req_o,
    input  logic        net_cmd_ack_i,
    output logic [63:0] net_cmd_h_o,
    output logic [63:0] net_cmd_dt_o,
    output logic        net_cmd_loop_o,
    output logic        fwd_vld_o,
    input  logic        fwd_rdy_i,
    output logic [63:0] fwd_h_o,
    output logic [63:0] fwd_dt_o,
    output logic        err_o
`ifdef QNET_DEC_STATS_EN
    ,
    output logic [15:0] stat_rx_o,
    output logic [15:0] stat_loc_o,
    output logic [15:0] stat_fwd_o,
    output logic [15:0] stat_err_o
`endif
);
    import qnet_pkg::*;

    localparam int TO_W = $clog2(ACK_TO + 1);

    dec_state_t      state_reg, state_next;
    logic            req_reg, req_next;
    logic            vld_reg, vld_next;
    logic            loop_reg, loop_next;
    logic            err_reg, err_next;
    logic [9:0]      fwd_step_reg, fwd_step_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

    logic [127:0]    frame;
    logic            frame_vld;
    logic            frame_err;
    qnet_hdr_t       hdr;
    qnet_hdr_t       fwd_hdr;
    logic            hdr_valid;
    logic            is_local;
    logic            is_fwd;
    logic            step_ovf;
    logic [10:0]     step_plus;

    qnet_frame_rx u_frame_rx (
        .clk       (t_clk_i),
        .srst      (t_rst_i),
        .rx_en     (state_reg == ST_RX),
        .rx_tdata  (rx_tdata_i),
        .rx_tvalid (rx_tvalid_i),
        .rx_tlast  (rx_tlast_i),
        .frame     (frame),
        .frame_vld (frame_vld),
        .frame_err (frame_err)
    );

    assign hdr       = qnet_hdr_t'(frame[127:64]);
    assign hdr_valid = hdr.cfg[2];
    assign is_local  = hdr_valid & ((hdr.dest == param_ID) | (hdr.dest == BCAST_ID) | (hdr.src == param_ID));
    assign is_fwd    = hdr_valid & (hdr.src != param_ID) & (hdr.dest != param_ID);
    assign step_plus = step_inc(hdr.step);
    assign step_ovf  = step_plus > {1'b0, param_NN};

    always_ff @(posedge t_clk_i) begin
        if (t_rst_i) begin
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            vld_reg      <= 1'b0;
            loop_reg     <= 1'b0;
            err_reg      <= 1'b0;
            fwd_step_reg <= 10'd0;
            to_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            vld_reg      <= vld_next;
            loop_reg     <= loop_next;
            err_reg      <= err_next;
            fwd_step_reg <= fwd_step_next;
            to_cnt_reg   <= to_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        vld_next      = vld_reg;
        loop_next     = loop_reg;
        err_next      = 1'b0;
        fwd_step_next = fwd_step_reg;
        to_cnt_next   = to_cnt_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_RX;
            ST_RX: begin
                if (frame_vld) begin
                    state_next = ST_DEC;
                end else if (frame_err) begin
                    err_next   = 1'b1;
                    // An early tlast already closed the frame; a missing one leaves words to swallow.
                    state_next = rx_tlast_i ? ST_IDLE : ST_DROP;
                end
            end
            ST_DROP: begin
                if (rx_tvalid_i && rx_tlast_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DEC: begin
                err_next      = hdr_valid & step_ovf;
                req_next      = is_local;
                vld_next      = is_fwd & ~step_ovf;
                loop_next     = is_local & (hdr.src == param_ID);
                fwd_step_next = step_plus[9:0];
                to_cnt_next   = '0;
                state_next    = (is_local || (is_fwd && !step_ovf)) ? ST_DISP : ST_IDLE;
            end
            ST_DISP: begin
                if (req_reg) begin
                    if (net_cmd_ack_i) begin
                        req_next = 1'b0;
                    end else if (to_cnt_reg == TO_W'(ACK_TO - 1)) begin
                        req_next = 1'b0;
                        err_next = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end
                if (vld_reg && fwd_rdy_i) begin
                    vld_next = 1'b0;
                end
                if (!req_next && !vld_next) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fwd_hdr      = hdr;
        fwd_hdr.step = fwd_step_reg;
    end

    assign rx_tready_o    = (state_reg == ST_RX) || (state_reg == ST_DROP);
    assign net_cmd_req_o  = req_reg;
    assign net_cmd_h_o    = frame[127:64];
    assign net_cmd_dt_o   = frame[63:0];
    assign net_cmd_loop_o = loop_reg;
    assign fwd_vld_o      = vld_reg;
    assign fwd_h_o        = fwd_hdr;
    assign fwd_dt_o       = frame[63:0];
    assign err_o          = err_reg;

`ifdef QNET_DEC_STATS_EN
    logic [3:0] stat_inc;
    assign stat_inc = {err_reg, vld_reg & fwd_rdy_i, req_reg & net_cmd_ack_i, frame_vld};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge t_clk_i) begin
                if (t_rst_i) begin
                    cnt_reg <= 16'd0;
                end else if (stat_inc[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign stat_rx_o  = gen_stat[0].cnt_reg;
    assign stat_loc_o = gen_stat[1].cnt_reg;
    assign stat_fwd_o = gen_stat[2].cnt_reg;
    assign stat_err_o = gen_stat[3].cnt_reg;
`endif

endmodule
